// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller
//   Build option: FETCH_HALT_DETECT_EN adds the HALT state to state_e.
package fetch_pkg;

    localparam int          INSTR_W = 16;
    localparam logic [15:0] NOP     = 16'h0800;
    localparam logic [4:0]  HALT_OP = 5'b00000;

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic [1:0] {FETCH, WAIT, HALT} state_e;
`else
    typedef enum logic [1:0] {FETCH, WAIT} state_e;
`endif

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a fetched word that decode could not take
//   clk, rst      : clock, synchronous active-high reset
//   wr_i          : capture instr_i/pc_i and mark valid
//   rd_i          : entry consumed, clear valid
//   flush_i       : discard entry (redirect)
//   instr_i, pc_i : word and its PC+2 to hold
//   valid_o, instr_o, pc_o : held entry
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_i,
    input  logic               rd_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [15:0]        pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [15:0]        pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [15:0]        pc_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q <= 1'b0;
        end else if (wr_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (rd_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller feeding the IF/ID pipeline register
//   Params : RESET_PC  PC loaded on reset
//   Inputs : clk, rst (sync, active-high), stall (decode hazard hold),
//            redirect/redirect_pc (taken branch/jump), imem_rdata/imem_done/imem_stall
//   Outputs: imem_rd/imem_addr (memory request), PCout/instrOut/ifid_write (IF/ID load),
//            halted (fetch stopped on HALT opcode)
//   Build option: FETCH_HALT_DETECT_EN enables HALT opcode detection.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [15:0]        redirect_pc,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_done,
    input  logic               imem_stall,
    output logic               imem_rd,
    output logic [15:0]        imem_addr,
    output logic [15:0]        PCout,
    output logic [INSTR_W-1:0] instrOut,
    output logic               ifid_write,
    output logic               halted
);

    state_e             state_q, state_d;
    logic [15:0]        pc_q, pc_d, pc_inc;
    logic               squash_q, squash_d;
    logic               outstanding;
    logic               buf_wr, buf_rd, buf_valid;
    logic [INSTR_W-1:0] buf_instr;
    logic [15:0]        buf_pc;

    assign pc_inc = pc_q + 16'd2;
    // A read is still in flight at the memory while waiting or while a squashed one drains.
    assign outstanding = (state_q == WAIT) || squash_q;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (buf_wr),
        .rd_i    (buf_rd),
        .flush_i (redirect),
        .instr_i (imem_rdata),
        .pc_i    (pc_inc),
        .valid_o (buf_valid),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        squash_d   = squash_q;
        buf_wr     = 1'b0;
        buf_rd     = 1'b0;
        imem_rd    = 1'b0;
        imem_addr  = pc_q;
        PCout      = pc_inc;
        instrOut   = imem_rdata;
        ifid_write = 1'b0;
        if (rst) begin
            // A read abandoned by reset may still return; drop it unless it returns now.
            squash_d = outstanding && !imem_done;
        end else if (redirect) begin
            state_d    = FETCH;
            pc_d       = {redirect_pc[15:1], 1'b0};
            squash_d   = outstanding && !imem_done;
            ifid_write = 1'b1;
            instrOut   = NOP;
            PCout      = {redirect_pc[15:1], 1'b0};
        end else if (state_q == WAIT) begin
            imem_rd = 1'b1;
            if (imem_done) begin
                state_d    = FETCH;
                pc_d       = pc_inc;
                ifid_write = !stall;
                buf_wr     = stall;
            end
        end else if (state_q == FETCH) begin
            if (squash_q) begin
                squash_d = !imem_done;
            end else if (!stall && buf_valid) begin
                buf_rd     = 1'b1;
                ifid_write = 1'b1;
                instrOut   = buf_instr;
                PCout      = buf_pc;
            end else if (!stall) begin
                imem_rd = 1'b1;
                if (imem_done) begin
                    pc_d       = pc_inc;
                    ifid_write = 1'b1;
                end else if (imem_stall) begin
                    state_d = WAIT;
                end
            end
        end
`ifdef FETCH_HALT_DETECT_EN
        if (ifid_write && !redirect && instrOut[15:11] == HALT_OP)
            state_d = HALT;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= {RESET_PC[15:1], 1'b0};
            squash_q <= squash_d;
        end else begin
            state_q  <= state_d;
            pc_q     <= {pc_d[15:1], 1'b0};
            squash_q <= squash_d;
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
